// File: rtl/pc_stack_unit.sv
// Program counter with load/increment/hold and a hardware call/return stack.
// Define PC_STACK_CIRCULAR_EN to make a Call on a full stack overwrite the oldest entry.
module pc_stack_unit #(
    parameter int word_size   = 8,
    parameter int stack_depth = 4,
    parameter int ptr_size    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] data_in,
    input  logic                 Load_PC,
    input  logic                 Inc_PC,
    input  logic                 Call,
    input  logic                 Ret,
    input  logic                 Clr_Err,
    output logic [word_size-1:0] count,
    output logic                 stack_full,
    output logic                 stack_empty,
    output logic [ptr_size:0]    depth,
    output logic                 ovf_err,
    output logic                 unf_err
);

    localparam logic [ptr_size:0] DEPTH_MAX = (ptr_size+1)'(stack_depth);

    logic [word_size-1:0] count_q, count_d;
    logic [ptr_size:0]    depth_q, depth_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [word_size-1:0] stack_q [stack_depth];
    logic [ptr_size-1:0]  push_idx, top_idx;
    logic                 push, shift;
    logic                 full, empty;

    assign full     = (depth_q == DEPTH_MAX);
    assign empty    = (depth_q == '0);
    assign push_idx = depth_q[ptr_size-1:0];
    assign top_idx  = push_idx - 1'b1;

    always_comb begin
        count_d = count_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        shift   = 1'b0;
        // Clear first so that a set in the same cycle overrides it.
        if (Clr_Err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (Ret) begin
            if (!empty) begin
                count_d = stack_q[top_idx];
                depth_d = depth_q - 1'b1;
            end else begin
                unf_d = 1'b1;
            end
        end else if (Call) begin
            if (!full) begin
                push    = 1'b1;
                count_d = data_in;
                depth_d = depth_q + 1'b1;
            end else begin
`ifdef PC_STACK_CIRCULAR_EN
                shift   = 1'b1;
                count_d = data_in;
`else
                ovf_d   = 1'b1;
`endif
            end
        end else if (Load_PC) begin
            count_d = data_in;
        end else if (Inc_PC) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage needs no reset; an overwrite on full drops entry 0 (the oldest).
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= count_q;
        end else if (shift) begin
            for (int i = 0; i < stack_depth - 1; i++) begin
                stack_q[i] <= stack_q[i+1];
            end
            stack_q[stack_depth-1] <= count_q;
        end
    end

    assign count       = count_q;
    assign depth       = depth_q;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;
    assign stack_full  = full;
    assign stack_empty = empty;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed plan steps then random commands
// compared against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int PTR   = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic         Load_PC, Inc_PC, Call, Ret, Clr_Err;
    logic [W-1:0] count;
    logic         stack_full, stack_empty;
    logic [PTR:0] depth;
    logic         ovf_err, unf_err;

    pc_stack_unit #(.word_size(W), .stack_depth(DEPTH), .ptr_size(PTR)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .Load_PC     (Load_PC),
        .Inc_PC      (Inc_PC),
        .Call        (Call),
        .Ret         (Ret),
        .Clr_Err     (Clr_Err),
        .count       (count),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .depth       (depth),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: PC value, return-address queue (back = top), sticky flags.
    int       m_count;
    int       m_stack[$];
    bit       m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(input bit r, input bit c, input bit l, input bit i,
                              input bit clr, input int din);
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (r) begin
            if (m_stack.size() > 0) m_count = m_stack.pop_back();
            else m_unf = 1;
        end else if (c) begin
            if (m_stack.size() < DEPTH) begin
                m_stack.push_back(m_count);
                m_count = din;
            end else begin
`ifdef PC_STACK_CIRCULAR_EN
                void'(m_stack.pop_front());
                m_stack.push_back(m_count);
                m_count = din;
`else
                m_ovf = 1;
`endif
            end
        end else if (l) begin
            m_count = din;
        end else if (i) begin
            m_count = (m_count + 1) % (1 << W);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".depth"}, 32'(depth), 32'(m_stack.size()));
        chk({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
        chk({tag, ".ovf"},   32'(ovf_err), 32'(m_ovf));
        chk({tag, ".unf"},   32'(unf_err), 32'(m_unf));
    endtask

    task automatic step(input string tag, input bit r, input bit c, input bit l,
                        input bit i, input bit clr, input int din);
        Ret = r; Call = c; Load_PC = l; Inc_PC = i; Clr_Err = clr;
        data_in = W'(din);
        @(posedge clk);
        #1;
        model_step(r, c, l, i, clr, din);
        check_all(tag);
        Ret = 0; Call = 0; Load_PC = 0; Inc_PC = 0; Clr_Err = 0;
    endtask

    initial begin
        rst = 1'b0;
        data_in = '0;
        Load_PC = 0; Inc_PC = 0; Call = 0; Ret = 0; Clr_Err = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        repeat (3) step("inc3", 0, 0, 0, 1, 0, 0);
        chk("inc3.literal", 32'(count), 32'h03);

        // Asynchronous reset between edges must clear without a clock.
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;

        step("load10", 0, 0, 1, 0, 0, 8'h10);
        step("call80", 0, 1, 0, 0, 0, 8'h80);
        chk("call80.literal", 32'(count), 32'h80);
        step("ret10",  1, 0, 0, 0, 0, 0);
        chk("ret10.literal", 32'(count), 32'h10);

        for (int k = 0; k < 4; k++) begin
            step("nest.load", 0, 0, 1, 0, 0, k + 1);
            step("nest.call", 0, 1, 0, 0, 0, 8'h40 + k);
        end
        chk("nest.full", 32'(stack_full), 32'h1);
        step("nest.load5", 0, 0, 1, 0, 0, 8'h05);
        step("nest.call5", 0, 1, 0, 0, 0, 8'h44);
`ifdef PC_STACK_CIRCULAR_EN
        chk("nest.call5.count", 32'(count), 32'h44);
`else
        chk("nest.call5.count", 32'(count), 32'h05);
        chk("nest.call5.ovf",   32'(ovf_err), 32'h1);
`endif
        for (int k = 0; k < 4; k++) step("nest.ret", 1, 0, 0, 0, 0, 0);
        chk("nest.ret.last", 32'(count), 32'h02 - ((DEPTH == 4) ? 0 : 0) -
`ifdef PC_STACK_CIRCULAR_EN
            0);
`else
            1);
`endif

        step("unf.ret",   1, 0, 0, 0, 0, 0);
        chk("unf.set", 32'(unf_err), 32'h1);
        step("unf.clr",   0, 0, 0, 0, 1, 0);
        chk("unf.cleared", 32'(unf_err), 32'h0);
        step("unf.clrret", 1, 0, 0, 0, 1, 0);
        chk("unf.setwins", 32'(unf_err), 32'h1);
        step("prio.clr",  0, 0, 0, 0, 1, 0);

        step("prio.load", 0, 0, 1, 0, 0, 8'h22);
        step("prio.call", 0, 1, 0, 0, 0, 8'h30);
        step("prio.all",  1, 1, 1, 1, 0, 8'h99);
        chk("prio.literal", 32'(count), 32'h22);

        step("wrap.load", 0, 0, 1, 0, 0, 8'hFF);
        step("wrap.inc",  0, 0, 0, 1, 0, 0);
        chk("wrap.literal", 32'(count), 32'h00);
        step("loadinc",   0, 0, 1, 1, 0, 8'h5A);
        chk("loadinc.literal", 32'(count), 32'h5A);

        for (int n = 0; n < 400; n++) begin
            step("rand",
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
